// File: rtl/zigbee_pkg.sv
// rtl/zigbee_pkg.sv - shared 802.15.4 chip constants, types and PN table
// Purpose: symbol/chip definitions shared by the transmit spreader and the
//          receive despreader.
// Contents: CHIPS_PER_SYM, chip_seq_t (c0 at bit 31), pn_chips(), tx_state_t.
package zigbee_pkg;

   localparam int CHIPS_PER_SYM = 32;

   typedef logic [31:0] chip_seq_t;

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_t;

   // Symbol 0 chips c0..c31, c0 in the MSB.
   localparam chip_seq_t PN_BASE       = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
   // Selects the odd-indexed chips c1, c3, ... (bits 30, 28, ...).
   localparam chip_seq_t ODD_CHIP_MASK = 32'h5555_5555;

   // Symbols 1..7 are symbol 0 rotated right by 4 chips per step; with c0 in the
   // MSB a chip rotation to higher indices is a plain right rotation of the word.
   // Symbols 8..15 reuse 0..7 with the odd chips inverted.
   function automatic chip_seq_t pn_chips(input logic [3:0] sym);
      logic [63:0] dbl;
      dbl = {PN_BASE, PN_BASE} >> {sym[2:0], 2'b00};
      return dbl[31:0] ^ (sym[3] ? ODD_CHIP_MASK : chip_seq_t'(0));
   endfunction

endpackage

// File: rtl/chip_rate_gen.sv
// rtl/chip_rate_gen.sv - mod-CLK_PER_CHIP chip-period counter
// Purpose: divides the work clock into chip periods.
// Ports:
//   i_clk    work clock
//   i_rst    asynchronous active-low reset
//   i_clr    hold the counter at zero
//   o_tc     terminal count (last cycle of a chip period), suppressed while cleared
//   o_first  counter is at zero (first cycle of a chip period)
module chip_rate_gen #(
   parameter int CLK_PER_CHIP = 25,
   localparam int CNT_W = $clog2(CLK_PER_CHIP)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tc,
   output logic o_first
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLK_PER_CHIP - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      o_tc    = ~i_clr & (cnt_q == TC_VAL);
      o_first = (cnt_q == '0);
      cnt_d   = (i_clr | o_tc) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/chip_spreader_tx.sv
// rtl/chip_spreader_tx.sv - 802.15.4 DSSS transmit chip spreader
// Purpose: accepts 4-bit symbols, maps each to its 32-chip PN sequence and
//          serialises the chips NRZ at CLK_PER_CHIP work clocks per chip.
// Ports:
//   i_clk, i_rst            work clock, asynchronous active-low reset
//   i_en                    transmit enable
//   i_sym, i_sym_valid      symbol input; o_sym_ready = holding register empty
//   o_dir                   serial chip stream, c0 first
//   o_chip_stb              pulse in the first cycle of each chip
//   o_busy                  a symbol is on o_dir
//   o_underrun              pulse when a symbol ends with i_en high and nothing queued
module chip_spreader_tx
   import zigbee_pkg::*;
#(
   parameter int CLK_PER_CHIP = 25
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [3:0] i_sym,
   input  logic       i_sym_valid,
   output logic       o_sym_ready,
   output logic       o_dir,
   output logic       o_chip_stb,
   output logic       o_busy,
   output logic       o_underrun
);

   tx_state_t  state_q, state_d;
   logic       hold_valid_q, hold_valid_d;
   logic [3:0] hold_sym_q, hold_sym_d;
   chip_seq_t  shreg_q, shreg_d;
   logic [4:0] chip_cnt_q, chip_cnt_d;
   logic       und_q, und_d;
   logic       dir_q, dir_d;
   logic       stb_q, stb_d;
   logic       busy_q, busy_d;
   logic       underrun_q, underrun_d;

   logic       rate_clr, rate_tc, rate_first;
   logic       load, accept;

   assign rate_clr = (state_q != TX_SEND);

   chip_rate_gen #(
      .CLK_PER_CHIP(CLK_PER_CHIP)
   ) u_rate (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (rate_clr),
      .o_tc    (rate_tc),
      .o_first (rate_first)
   );

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_sym_d   = hold_sym_q;
      shreg_d      = shreg_q;
      chip_cnt_d   = chip_cnt_q;
      und_d        = 1'b0;
      load         = 1'b0;
      accept       = i_sym_valid & ~hold_valid_q;

      case (state_q)
         TX_IDLE: begin
            if (hold_valid_q & i_en) begin
               load    = 1'b1;
               state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (rate_tc) begin
               if (chip_cnt_q == 5'(CHIPS_PER_SYM - 1)) begin
                  // A queued symbol only follows while enabled; a pending symbol
                  // with i_en low waits in the holding register.
                  if (hold_valid_q & i_en) begin
                     load = 1'b1;
                  end else begin
                     state_d = TX_IDLE;
                     und_d   = i_en;
                  end
                  chip_cnt_d = '0;
               end else begin
                  chip_cnt_d = chip_cnt_q + 5'd1;
                  shreg_d    = {shreg_q[30:0], 1'b0};
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase

      // Load consumes the old holding content before an accept refills it.
      if (load) begin
         shreg_d      = pn_chips(hold_sym_q);
         chip_cnt_d   = '0;
         hold_valid_d = 1'b0;
      end
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_sym_d   = i_sym;
      end

      // Outputs are registered one cycle behind the internal chip state, so the
      // underrun flag is delayed once more to line up with o_busy falling.
      dir_d      = (state_q == TX_SEND) & shreg_q[31];
      stb_d      = (state_q == TX_SEND) & rate_first;
      busy_d     = (state_q == TX_SEND);
      underrun_d = und_q;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= TX_IDLE;
         hold_valid_q <= 1'b0;
         hold_sym_q   <= '0;
         shreg_q      <= '0;
         chip_cnt_q   <= '0;
         und_q        <= 1'b0;
         dir_q        <= 1'b0;
         stb_q        <= 1'b0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_sym_q   <= hold_sym_d;
         shreg_q      <= shreg_d;
         chip_cnt_q   <= chip_cnt_d;
         und_q        <= und_d;
         dir_q        <= dir_d;
         stb_q        <= stb_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign o_sym_ready = ~hold_valid_q;
   assign o_dir       = dir_q;
   assign o_chip_stb  = stb_q;
   assign o_busy      = busy_q;
   assign o_underrun  = underrun_q;

endmodule
